// File: rtl/ctrl_step_sequencer.sv
// rtl/ctrl_step_sequencer.sv - hardwired control-step FSM generating datapath strobes
// Optional feature macro: CTRL_SINGLE_STEP_EN (adds Step input; state advances only when Step=1)
module ctrl_step_sequencer #(
    parameter int OPCODE_W    = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                MemReady,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic                Step,
`endif
    output logic [23:0]         ctrl,
    output logic [3:0]          Present_state,
    output logic                InstrDone,
    output logic                Illegal,
    output logic                BusErr,
    output logic                Halted
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [3:0] S_IDLE = 4'b0000;
    localparam logic [3:0] S_T0   = 4'b0111;
    localparam logic [3:0] S_T1   = 4'b1000;
    localparam logic [3:0] S_T2   = 4'b1001;
    localparam logic [3:0] S_T3   = 4'b1010;
    localparam logic [3:0] S_T4   = 4'b1011;
    localparam logic [3:0] S_T5   = 4'b1100;
    localparam logic [3:0] S_T6   = 4'b1101;
    localparam logic [3:0] S_HALT = 4'b1111;

    // Opcode classes
    localparam logic [3:0] C_ALU  = 4'd0;
    localparam logic [3:0] C_MD   = 4'd1;
    localparam logic [3:0] C_IN   = 4'd2;
    localparam logic [3:0] C_OUT  = 4'd3;
    localparam logic [3:0] C_MFHI = 4'd4;
    localparam logic [3:0] C_MFLO = 4'd5;
    localparam logic [3:0] C_NOP  = 4'd6;
    localparam logic [3:0] C_HALT = 4'd7;
    localparam logic [3:0] C_ILL  = 4'd8;

    // Strobe bit positions
    localparam int B_PCOUT     = 0;
    localparam int B_PCIN      = 1;
    localparam int B_INCPC     = 2;
    localparam int B_MARIN     = 3;
    localparam int B_MDRIN     = 4;
    localparam int B_MDROUT    = 5;
    localparam int B_READ      = 6;
    localparam int B_IRIN      = 8;
    localparam int B_YIN       = 9;
    localparam int B_ZIN       = 10;
    localparam int B_ZLOWOUT   = 11;
    localparam int B_ZHIGHOUT  = 12;
    localparam int B_HIIN      = 13;
    localparam int B_HIOUT     = 14;
    localparam int B_LOIN      = 15;
    localparam int B_LOOUT     = 16;
    localparam int B_INPORTOUT = 17;
    localparam int B_OUTPORTIN = 18;
    localparam int B_GRA       = 19;
    localparam int B_GRB       = 20;
    localparam int B_GRC       = 21;
    localparam int B_RIN       = 22;
    localparam int B_ROUT      = 23;

    logic [3:0]       state;
    logic [CNT_W-1:0] t1_cnt;
    logic [CNT_W-1:0] t1_cnt_inc;
    logic [3:0]       op_class;
    logic             adv;
    logic [23:0]      ctrl_c;

`ifdef CTRL_SINGLE_STEP_EN
    assign adv = Step;
`else
    assign adv = 1'b1;
`endif

    assign t1_cnt_inc    = t1_cnt + 1'b1;
    assign Present_state = state;
    assign Halted        = (state == S_HALT);
    assign ctrl          = ctrl_c;

    // Classify the opcode into the execute-sequence families
    always_comb begin
        op_class = C_ILL;
        if (opcode <= OPCODE_W'(10))                  op_class = C_ALU;
        else if (opcode == OPCODE_W'(14) ||
                 opcode == OPCODE_W'(15))             op_class = C_MD;
        else if (opcode == OPCODE_W'(22))             op_class = C_IN;
        else if (opcode == OPCODE_W'(23))             op_class = C_OUT;
        else if (opcode == OPCODE_W'(24))             op_class = C_MFHI;
        else if (opcode == OPCODE_W'(25))             op_class = C_MFLO;
        else if (opcode == OPCODE_W'(26))             op_class = C_NOP;
        else if (opcode == OPCODE_W'(27))             op_class = C_HALT;
    end

    // Moore strobe decode from the current step and opcode class
    always_comb begin
        ctrl_c = 24'h0;
        case (state)
            S_T0: begin
                ctrl_c[B_PCOUT] = 1'b1;
                ctrl_c[B_MARIN] = 1'b1;
                ctrl_c[B_INCPC] = 1'b1;
                ctrl_c[B_PCIN]  = 1'b1;
            end
            S_T1: begin
                ctrl_c[B_READ]  = 1'b1;
                ctrl_c[B_MDRIN] = 1'b1;
            end
            S_T2: begin
                ctrl_c[B_MDROUT] = 1'b1;
                ctrl_c[B_IRIN]   = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    C_ALU, C_MD: begin
                        ctrl_c[B_GRB]  = 1'b1;
                        ctrl_c[B_ROUT] = 1'b1;
                        ctrl_c[B_YIN]  = 1'b1;
                    end
                    C_IN: begin
                        ctrl_c[B_GRA]       = 1'b1;
                        ctrl_c[B_RIN]       = 1'b1;
                        ctrl_c[B_INPORTOUT] = 1'b1;
                    end
                    C_OUT: begin
                        ctrl_c[B_GRA]       = 1'b1;
                        ctrl_c[B_ROUT]      = 1'b1;
                        ctrl_c[B_OUTPORTIN] = 1'b1;
                    end
                    C_MFHI: begin
                        ctrl_c[B_GRA]   = 1'b1;
                        ctrl_c[B_RIN]   = 1'b1;
                        ctrl_c[B_HIOUT] = 1'b1;
                    end
                    C_MFLO: begin
                        ctrl_c[B_GRA]   = 1'b1;
                        ctrl_c[B_RIN]   = 1'b1;
                        ctrl_c[B_LOOUT] = 1'b1;
                    end
                    default: ctrl_c = 24'h0;
                endcase
            end
            S_T4: begin
                if (op_class == C_ALU || op_class == C_MD) begin
                    ctrl_c[B_GRC]  = 1'b1;
                    ctrl_c[B_ROUT] = 1'b1;
                    ctrl_c[B_ZIN]  = 1'b1;
                end
            end
            S_T5: begin
                if (op_class == C_ALU) begin
                    ctrl_c[B_ZLOWOUT] = 1'b1;
                    ctrl_c[B_GRA]     = 1'b1;
                    ctrl_c[B_RIN]     = 1'b1;
                end else if (op_class == C_MD) begin
                    ctrl_c[B_ZLOWOUT] = 1'b1;
                    ctrl_c[B_LOIN]    = 1'b1;
                end
            end
            S_T6: begin
                if (op_class == C_MD) begin
                    ctrl_c[B_ZHIGHOUT] = 1'b1;
                    ctrl_c[B_HIIN]     = 1'b1;
                end
            end
            default: ctrl_c = 24'h0;
        endcase
    end

    // Step register, T1 timeout counter and registered one-cycle status pulses
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_IDLE;
            t1_cnt    <= '0;
            InstrDone <= 1'b0;
            Illegal   <= 1'b0;
            BusErr    <= 1'b0;
        end else begin
            InstrDone <= 1'b0;
            Illegal   <= 1'b0;
            BusErr    <= 1'b0;
            if (adv) begin
                case (state)
                    S_IDLE: if (Run) state <= S_T0;
                    S_T0: begin
                        state  <= S_T1;
                        t1_cnt <= '0;
                    end
                    S_T1: begin
                        if (MemReady) begin
                            state <= S_T2;
                        end else if (t1_cnt_inc == CNT_W'(MEM_TIMEOUT)) begin
                            BusErr <= 1'b1;
                            state  <= S_IDLE;
                            t1_cnt <= '0;
                        end else begin
                            t1_cnt <= t1_cnt_inc;
                        end
                    end
                    S_T2: state <= S_T3;
                    S_T3: begin
                        case (op_class)
                            C_ALU, C_MD: state <= S_T4;
                            C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP: begin
                                InstrDone <= 1'b1;
                                state     <= Run ? S_T0 : S_IDLE;
                            end
                            C_HALT: state <= S_HALT;
                            default: begin
                                Illegal <= 1'b1;
                                state   <= S_T0;
                            end
                        endcase
                    end
                    S_T4: begin
                        if (op_class == C_ALU || op_class == C_MD) begin
                            state <= S_T5;
                        end else begin
                            Illegal <= 1'b1;
                            state   <= S_T0;
                        end
                    end
                    S_T5: begin
                        if (op_class == C_ALU) begin
                            InstrDone <= 1'b1;
                            state     <= Run ? S_T0 : S_IDLE;
                        end else if (op_class == C_MD) begin
                            state <= S_T6;
                        end else begin
                            Illegal <= 1'b1;
                            state   <= S_T0;
                        end
                    end
                    S_T6: begin
                        if (op_class == C_MD) begin
                            InstrDone <= 1'b1;
                            state     <= Run ? S_T0 : S_IDLE;
                        end else begin
                            Illegal <= 1'b1;
                            state   <= S_T0;
                        end
                    end
                    S_HALT:  state <= S_HALT;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
